// File: rtl/layer0_input_packer.sv
// Packs a stream of signed feature beats into one frame of 2-bit threshold codes
// for the layer-0 neurons, with a single-entry output register for handoff.
module layer0_input_packer #(
  parameter int NUM_FEAT = 16,
  parameter int IN_W = 8,
  parameter logic signed [IN_W-1:0] T0 = IN_W'(-32),
  parameter logic signed [IN_W-1:0] T1 = IN_W'(0),
  parameter logic signed [IN_W-1:0] T2 = IN_W'(32)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic signed [IN_W-1:0]     s_data,
  input  logic                       s_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [2*NUM_FEAT-1:0]      m_data,
  output logic                       m_len_err
);

  localparam int IDX_W = $clog2(NUM_FEAT);
  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [2*NUM_FEAT-1:0] asm_q, asm_d;
  logic                  asm_err_q, asm_err_d;
  logic                  live_q, live_d;
  logic                  out_valid_q, out_valid_d;
  logic [2*NUM_FEAT-1:0] out_data_q, out_data_d;
  logic                  out_err_q, out_err_d;

  logic [1:0] code;
  logic       accept;
  logic       at_end;
  logic       handoff;

  // s_ready is held low through reset and the first clock after it by live_q.
  assign s_ready   = live_q && (state_q == FILL);
  assign m_valid   = out_valid_q;
  assign m_data    = out_data_q;
  assign m_len_err = out_err_q;

  always_comb begin
    if (s_data < T0)      code = 2'd0;
    else if (s_data < T1) code = 2'd1;
    else if (s_data < T2) code = 2'd2;
    else                  code = 2'd3;
  end

  always_comb begin
    accept  = s_valid && s_ready;
    at_end  = (idx_q == IDX_W'(NUM_FEAT - 1));
    handoff = (state_q == FULL) && (!out_valid_q || m_ready);

    state_d     = state_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    asm_err_d   = asm_err_q;
    live_d      = 1'b1;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;

    if (accept) begin
      // Clearing on the first beat leaves unreceived slots zero after an early s_last.
      if (idx_q == '0) asm_d = '0;
      for (int unsigned i = 0; i < NUM_FEAT; i++) begin
        if (idx_q == IDX_W'(i)) asm_d[2*i +: 2] = code;
      end
      asm_err_d = s_last ^ at_end;
      if (s_last || at_end) state_d = FULL;
      else                  idx_d   = idx_q + 1'b1;
    end

    if (handoff) begin
      out_valid_d = 1'b1;
      out_data_d  = asm_q;
      out_err_d   = asm_err_q;
      state_d     = FILL;
      idx_d       = '0;
    end else if (out_valid_q && m_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      idx_q       <= '0;
      asm_q       <= '0;
      asm_err_q   <= 1'b0;
      live_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      asm_err_q   <= asm_err_d;
      live_q      <= live_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
    end
  end

endmodule
